// File: rtl/tick_divider_pkg.sv
// tick_divider_pkg
// Shared definitions for the tick divider bank:
//   mode_e        - output shaping mode of a channel (square wave or one-cycle pulse)
//   ch_w()        - width of the channel-select field for a given channel count (min 1)
//   clamp_div_lsb - forces a zero divisor up to 1 by setting its LSB
package tick_divider_pkg;

  typedef enum logic {
    MODE_SQUARE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  // Width of the channel index; a single-channel bank still gets a 1-bit select
  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // A divisor of 0 is meaningless, so it is stored as 1. Only the LSB can
  // change under the clamp, which keeps this helper width-independent.
  function automatic logic clamp_div_lsb(input logic lsb, input logic is_zero);
    return lsb | is_zero;
  endfunction

endpackage

// File: rtl/tick_divider_channel.sv
// tick_divider_channel
// One channel of the tick divider bank: counter, active/shadow divisor,
// pending flag, mode and (optionally) phase register.
// Optional feature macro: DIVIDER_PHASE_EN (per-channel phase loaded on sync).
// Ports:
//   clock     in   system clock, rising edge
//   resetn    in   synchronous active-low reset
//   en        in   run enable (level)
//   sync      in   restart this channel on this edge
//   wr_sel    in   configuration write addressed to this channel
//   wr_div    in   new divisor (0 is stored as 1)
//   wr_mode   in   0 = square, 1 = pulse
//   wr_phase  in   phase offset (only used with DIVIDER_PHASE_EN)
//   clk_out   out  square (or pulse) output, registered
//   tick      out  one-cycle pulse per period, registered
//   pending   out  shadow divisor written but not yet applied
module tick_divider_channel
  import tick_divider_pkg::*;
#(
  parameter int CNT_W       = 28,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             en,
  input  logic             sync,
  input  logic             wr_sel,
  input  logic [CNT_W-1:0] wr_div,
  input  logic             wr_mode,
  input  logic [CNT_W-1:0] wr_phase,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] shadow;
  mode_e            mode;

  logic [CNT_W-1:0] div_in;
  logic             at_top;
  logic [CNT_W-1:0] cnt_inc;
  logic             apply;
  mode_e            mode_eff;
  logic             run_clk;
  logic [CNT_W-1:0] sync_div;
  logic [CNT_W-1:0] load_cnt;
  logic             sync_clk;

  // Next-count and apply decisions. The wrap test uses >= so that a counter
  // left above a freshly shrunk divisor (applied while disabled) still wraps
  // instead of running all the way round the counter width.
  always_comb begin
    div_in    = wr_div;
    div_in[0] = clamp_div_lsb(wr_div[0], wr_div == '0);
    at_top    = (cnt >= div - CNT_W'(1));
    cnt_inc   = at_top ? '0 : cnt + CNT_W'(1);
    // Disabled channels have no period to finish, so they apply at once
    apply     = pending && (!en || at_top);
    mode_eff  = wr_sel ? mode_e'(wr_mode) : mode;
    if (mode_eff == MODE_PULSE) begin
      run_clk = (cnt_inc == '0);
    end else begin
      run_clk = (cnt_inc >= (div >> 1));
    end
    // Shadow equals div whenever nothing is pending, so sync can always take
    // the shadow (or a write landing on the same edge).
    sync_div  = wr_sel ? div_in : shadow;
  end

`ifdef DIVIDER_PHASE_EN
  logic [CNT_W-1:0] phase;
  logic [CNT_W-1:0] phase_eff;

  // Phase register, loaded by every valid write
  always_ff @(posedge clock) begin
    if (!resetn) begin
      phase <= '0;
    end else if (wr_sel) begin
      phase <= wr_phase;
    end
  end

  // On sync the counter starts at phase mod the post-sync divisor, and the
  // square output reflects that starting count. Tick stays low on the sync
  // edge itself, matching a restart from zero.
  always_comb begin
    phase_eff = wr_sel ? wr_phase : phase;
    load_cnt  = phase_eff % sync_div;
    sync_clk  = (mode_eff == MODE_SQUARE) && (load_cnt >= (sync_div >> 1));
  end
`else
  logic unused_phase;
  assign unused_phase = ^wr_phase;

  // Without phase support a sync always restarts from zero with outputs low
  always_comb begin
    load_cnt = '0;
    sync_clk = 1'b0;
  end
`endif

  // Channel state. Priority: reset, then sync, then normal counting.
  // A write updates shadow and mode on its own edge; pending is managed
  // together with the apply logic below so a write on a wrap edge stays
  // pending for the following period.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt     <= '0;
      div     <= CNT_W'(DEFAULT_DIV);
      shadow  <= CNT_W'(DEFAULT_DIV);
      mode    <= MODE_SQUARE;
      pending <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      if (wr_sel) begin
        shadow <= div_in;
        mode   <= mode_e'(wr_mode);
      end
      if (sync) begin
        div     <= sync_div;
        pending <= 1'b0;
        cnt     <= load_cnt;
        clk_out <= sync_clk;
        tick    <= 1'b0;
      end else begin
        if (en) begin
          cnt     <= cnt_inc;
          tick    <= (cnt_inc == '0);
          clk_out <= run_clk;
        end else begin
          tick    <= 1'b0;
        end
        if (apply) begin
          div <= shadow;
        end
        if (wr_sel) begin
          pending <= 1'b1;
        end else if (apply) begin
          pending <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/tick_divider_bank.sv
// tick_divider_bank
// Multi-channel clock-enable generator. Each channel has a programmable
// divisor (applied glitch-free at the end of the current period), a
// square/pulse mode and a run enable; sync restarts every channel at once.
// Optional feature macro: DIVIDER_PHASE_EN (per-channel phase offset on sync).
// Ports:
//   clock        in   system clock, rising edge
//   resetn       in   synchronous active-low reset
//   wr_en        in   configuration write strobe
//   wr_ch        in   target channel (writes to wr_ch >= NUM_CH are ignored)
//   wr_div       in   new divisor
//   wr_mode      in   0 = square, 1 = pulse
//   wr_phase     in   phase offset (used only with DIVIDER_PHASE_EN)
//   ch_en        in   per-channel run enable
//   sync         in   restart all channels
//   clk_out      out  per-channel square output
//   tick         out  per-channel one-cycle pulse per period
//   div_pending  out  per-channel shadow divisor not yet applied
module tick_divider_bank
  import tick_divider_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 28,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      wr_en,
  input  logic [ch_w(NUM_CH)-1:0]   wr_ch,
  input  logic [CNT_W-1:0]          wr_div,
  input  logic                      wr_mode,
  input  logic [CNT_W-1:0]          wr_phase,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic                      sync,
  output logic [NUM_CH-1:0]         clk_out,
  output logic [NUM_CH-1:0]         tick,
  output logic [NUM_CH-1:0]         div_pending
);

  logic              wr_valid;
  logic [NUM_CH-1:0] wr_sel;

  // Decode the write into a one-hot channel select. The range check matters
  // when NUM_CH is not a power of two and wr_ch can address missing channels.
  always_comb begin
    wr_sel   = '0;
    wr_valid = wr_en && (32'(wr_ch) < 32'(NUM_CH));
    for (int i = 0; i < NUM_CH; i++) begin
      wr_sel[i] = wr_valid && (32'(wr_ch) == 32'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_divider_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clock    (clock),
      .resetn   (resetn),
      .en       (ch_en[g]),
      .sync     (sync),
      .wr_sel   (wr_sel[g]),
      .wr_div   (wr_div),
      .wr_mode  (wr_mode),
      .wr_phase (wr_phase),
      .clk_out  (clk_out[g]),
      .tick     (tick[g]),
      .pending  (div_pending[g])
    );
  end

endmodule

// File: tb/tb_tick_divider_bank.sv
// tb_tick_divider_bank
// Directed self-checking bench for tick_divider_bank, built with three
// channels so that wr_ch = NUM_CH is representable on the 2-bit select.
module tb_tick_divider_bank;

  localparam int NUM_CH      = 3;
  localparam int CNT_W       = 8;
  localparam int DEFAULT_DIV = 2;
`ifdef DIVIDER_PHASE_EN
  localparam int PHASE_LOAD  = 3;
`else
  localparam int PHASE_LOAD  = 0;
`endif

  logic              clock;
  logic              resetn;
  logic              wr_en;
  logic [1:0]        wr_ch;
  logic [CNT_W-1:0]  wr_div;
  logic              wr_mode;
  logic [CNT_W-1:0]  wr_phase;
  logic [NUM_CH-1:0] ch_en;
  logic              sync;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] div_pending;

  int checks = 0;
  int passes = 0;

  tick_divider_bank #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .wr_en       (wr_en),
    .wr_ch       (wr_ch),
    .wr_div      (wr_div),
    .wr_mode     (wr_mode),
    .wr_phase    (wr_phase),
    .ch_en       (ch_en),
    .sync        (sync),
    .clk_out     (clk_out),
    .tick        (tick),
    .div_pending (div_pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle before sampling/driving
  task automatic step_clock();
    @(posedge clock);
    #1;
  endtask

  // Reset state, then DEFAULT_DIV=2 on all channels: clk_out 1,0,1,0...
  // and tick on every even edge after release.
  task automatic test_reset();
    resetn = 1'b0;
    step_clock();
    checks++;
    if (clk_out !== 3'b000) $display("[TB] FAIL reset_clk_out: got %b expected %b", clk_out, 3'b000);
    else passes++;
    checks++;
    if (tick !== 3'b000) $display("[TB] FAIL reset_tick: got %b expected %b", tick, 3'b000);
    else passes++;
    checks++;
    if (div_pending !== 3'b000) $display("[TB] FAIL reset_pending: got %b expected %b", div_pending, 3'b000);
    else passes++;
    resetn = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step_clock();
      checks++;
      if (clk_out !== ((k % 2 == 1) ? 3'b111 : 3'b000))
        $display("[TB] FAIL default_clk_out edge %0d: got %b expected %b", k, clk_out, (k % 2 == 1) ? 3'b111 : 3'b000);
      else passes++;
      checks++;
      if (tick !== ((k % 2 == 0) ? 3'b111 : 3'b000))
        $display("[TB] FAIL default_tick edge %0d: got %b expected %b", k, tick, (k % 2 == 0) ? 3'b111 : 3'b000);
      else passes++;
    end
  endtask

  // Write ch1 div=5 one edge into a 2-cycle period: pending for one cycle,
  // old period completes, then 2 low / 3 high with a tick every 5 cycles.
  task automatic test_write_div();
    wr_en = 1'b1; wr_ch = 2'd1; wr_div = 8'd5; wr_mode = 1'b0;
    step_clock();
    wr_en = 1'b0;
    checks++;
    if (div_pending !== 3'b010) $display("[TB] FAIL write_pending_set: got %b expected %b", div_pending, 3'b010);
    else passes++;
    step_clock();
    checks++;
    if (tick[1] !== 1'b1) $display("[TB] FAIL write_old_period_tick: got %b expected %b", tick[1], 1'b1);
    else passes++;
    checks++;
    if (div_pending !== 3'b000) $display("[TB] FAIL write_pending_clear: got %b expected %b", div_pending, 3'b000);
    else passes++;
    for (int k = 1; k <= 10; k++) begin
      step_clock();
      checks++;
      if (clk_out[1] !== ((k % 5) >= 2))
        $display("[TB] FAIL div5_clk_out step %0d: got %b expected %b", k, clk_out[1], (k % 5) >= 2);
      else passes++;
      checks++;
      if (tick[1] !== ((k % 5) == 0))
        $display("[TB] FAIL div5_tick step %0d: got %b expected %b", k, tick[1], (k % 5) == 0);
      else passes++;
    end
  endtask

  // Pulse mode div=3 on ch0, then a div=0 write which must act as div=1
  task automatic test_pulse_mode();
    wr_en = 1'b1; wr_ch = 2'd0; wr_div = 8'd3; wr_mode = 1'b1;
    step_clock();
    wr_en = 1'b0;
    checks++;
    if (div_pending[0] !== 1'b1) $display("[TB] FAIL pulse_pending: got %b expected %b", div_pending[0], 1'b1);
    else passes++;
    for (int j = 0; j <= 6; j++) begin
      step_clock();
      checks++;
      if (tick[0] !== (j % 3 == 0))
        $display("[TB] FAIL pulse_tick step %0d: got %b expected %b", j, tick[0], j % 3 == 0);
      else passes++;
      checks++;
      if (clk_out[0] !== (j % 3 == 0))
        $display("[TB] FAIL pulse_clk_out step %0d: got %b expected %b", j, clk_out[0], j % 3 == 0);
      else passes++;
    end
    wr_en = 1'b1; wr_ch = 2'd0; wr_div = 8'd0; wr_mode = 1'b1;
    for (int j = 0; j < 6; j++) begin
      step_clock();
      wr_en = 1'b0;
      checks++;
      if (tick[0] !== (j >= 2))
        $display("[TB] FAIL div0_tick step %0d: got %b expected %b", j, tick[0], j >= 2);
      else passes++;
      checks++;
      if (clk_out[0] !== (j >= 2))
        $display("[TB] FAIL div0_clk_out step %0d: got %b expected %b", j, clk_out[0], j >= 2);
      else passes++;
    end
  endtask

  // Sync + write ch2 div=4, run two edges, freeze for 7, then resume
  task automatic test_disable();
    wr_en = 1'b1; wr_ch = 2'd2; wr_div = 8'd4; wr_mode = 1'b0; sync = 1'b1;
    step_clock();
    wr_en = 1'b0; sync = 1'b0;
    checks++;
    if ({div_pending[2], clk_out[2], tick[2]} !== 3'b000)
      $display("[TB] FAIL disable_sync_state: got %b expected %b", {div_pending[2], clk_out[2], tick[2]}, 3'b000);
    else passes++;
    step_clock();
    step_clock();
    checks++;
    if (clk_out[2] !== 1'b1) $display("[TB] FAIL disable_pre_clk_out: got %b expected %b", clk_out[2], 1'b1);
    else passes++;
    ch_en[2] = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step_clock();
      checks++;
      if ({clk_out[2], tick[2]} !== 2'b10)
        $display("[TB] FAIL disabled_hold step %0d: got %b expected %b", k, {clk_out[2], tick[2]}, 2'b10);
      else passes++;
    end
    ch_en[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step_clock();
      checks++;
      if (tick[2] !== (k == 1))
        $display("[TB] FAIL resume_tick step %0d: got %b expected %b", k, tick[2], k == 1);
      else passes++;
      checks++;
      if (clk_out[2] !== (k == 0))
        $display("[TB] FAIL resume_clk_out step %0d: got %b expected %b", k, clk_out[2], k == 0);
      else passes++;
    end
  endtask

  // Sync with a simultaneous write ch0 div=8 phase=3; ch1 (div 5) restarts too
  task automatic test_sync_write();
    int c0;
    int c1;
    wr_en = 1'b1; wr_ch = 2'd0; wr_div = 8'd8; wr_mode = 1'b0; wr_phase = 8'd3; sync = 1'b1;
    step_clock();
    wr_en = 1'b0; sync = 1'b0;
    checks++;
    if ({div_pending[0], clk_out[0], tick[0]} !== 3'b000)
      $display("[TB] FAIL sync_state: got %b expected %b", {div_pending[0], clk_out[0], tick[0]}, 3'b000);
    else passes++;
    for (int k = 1; k <= 16; k++) begin
      step_clock();
      c0 = (PHASE_LOAD + k) % 8;
      c1 = k % 5;
      checks++;
      if (tick[0] !== (c0 == 0))
        $display("[TB] FAIL sync_div8_tick step %0d: got %b expected %b", k, tick[0], c0 == 0);
      else passes++;
      checks++;
      if (clk_out[0] !== (c0 >= 4))
        $display("[TB] FAIL sync_div8_clk_out step %0d: got %b expected %b", k, clk_out[0], c0 >= 4);
      else passes++;
      checks++;
      if (tick[1] !== (c1 == 0))
        $display("[TB] FAIL sync_div5_tick step %0d: got %b expected %b", k, tick[1], c1 == 0);
      else passes++;
    end
  endtask

  // Out-of-range write ignored; reset with a pending write restores defaults
  task automatic test_reset_midflight();
    wr_en = 1'b1; wr_ch = 2'd3; wr_div = 8'd9; wr_mode = 1'b1;
    step_clock();
    checks++;
    if (div_pending !== 3'b000) $display("[TB] FAIL out_of_range_write: got %b expected %b", div_pending, 3'b000);
    else passes++;
    wr_ch = 2'd1; wr_div = 8'd7; wr_mode = 1'b0;
    step_clock();
    checks++;
    if (div_pending !== 3'b010) $display("[TB] FAIL midflight_pending: got %b expected %b", div_pending, 3'b010);
    else passes++;
    wr_div = 8'd9; resetn = 1'b0;
    step_clock();
    wr_en = 1'b0;
    checks++;
    if ({clk_out, tick, div_pending} !== 9'b0)
      $display("[TB] FAIL midflight_reset_outputs: got %b expected %b", {clk_out, tick, div_pending}, 9'b0);
    else passes++;
    resetn = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step_clock();
      checks++;
      if (clk_out !== ((k % 2 == 1) ? 3'b111 : 3'b000))
        $display("[TB] FAIL post_reset_clk_out edge %0d: got %b expected %b", k, clk_out, (k % 2 == 1) ? 3'b111 : 3'b000);
      else passes++;
      checks++;
      if (tick !== ((k % 2 == 0) ? 3'b111 : 3'b000))
        $display("[TB] FAIL post_reset_tick edge %0d: got %b expected %b", k, tick, (k % 2 == 0) ? 3'b111 : 3'b000);
      else passes++;
    end
  endtask

  initial begin
    resetn   = 1'b0;
    wr_en    = 1'b0;
    wr_ch    = 2'd0;
    wr_div   = '0;
    wr_mode  = 1'b0;
    wr_phase = '0;
    ch_en    = 3'b111;
    sync     = 1'b0;
    #2;
    test_reset();
    test_write_div();
    test_pulse_mode();
    test_disable();
    test_sync_write();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
